// File: rtl/periph_rr_arbiter_pkg.sv
// Shared definitions for the two-master peripheral arbiter: FSM encoding,
// requester ids and the register map of the shared slave.
package periph_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Word addresses of the peripheral register map
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/periph_rr_arbiter_grant.sv
// Combinational two-way round-robin pick; an active lock masks out
// everyone except the lock owner.
module rr_grant2
  import periph_rr_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       lock_active,
  input  logic       lock_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    if (lock_active) begin
      grant_valid = valid[lock_owner];
      grant_id    = lock_owner;
    end else begin
      unique case (valid)
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = REQ0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = REQ1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = other_req(last_grant);
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = REQ0;
        end
      endcase
    end
  end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter sharing one single-cycle register slave between two
// masters, with a bounded lock for read-modify-write sequences.
module periph_rr_arbiter
  import periph_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic [ADDR_W-1:0] p_addr,
  output logic              p_rd_en,
  output logic              p_wr_en,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata
);

  localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

  state_t state, state_next;

  logic       last_grant;
  logic       lock_active;
  logic       lock_owner;
  logic [3:0] lock_cnt;

  logic grant_valid;
  logic grant_id;
  logic accept;

  logic              acc_write;
  logic              acc_lock;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic              id_p1;
  logic              write_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] rdata0_p2;
  logic [DATA_W-1:0] rdata1_p2;

  rr_grant2 u_grant (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    acc_write = (grant_id == REQ1) ? req1_write : req0_write;
    acc_lock  = (grant_id == REQ1) ? req1_lock  : req0_lock;
    acc_addr  = (grant_id == REQ1) ? req1_addr  : req0_addr;
    acc_wdata = (grant_id == REQ1) ? req1_wdata : req0_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Ready is gated by reset so nothing looks accepted while reset is held
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    p_rd_en     = 1'b0;
    p_wr_en     = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (reset_n && grant_valid) begin
          accept     = 1'b1;
          req0_ready = (grant_id == REQ0);
          req1_ready = (grant_id == REQ1);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        p_rd_en    = !write_p1;
        p_wr_en    = write_p1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = (id_p1 == REQ0);
        resp1_valid = (id_p1 == REQ1);
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A lock that reaches its cap is dropped; last_grant then hands the next tie over
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant  <= REQ1;
      lock_active <= 1'b0;
      lock_owner  <= REQ0;
      lock_cnt    <= 4'd0;
    end else if (accept) begin
      last_grant <= grant_id;
      if (acc_lock && (lock_cnt < LOCK_LAST)) begin
        lock_active <= 1'b1;
        lock_owner  <= grant_id;
        lock_cnt    <= lock_cnt + 4'd1;
      end else begin
        lock_active <= 1'b0;
        lock_cnt    <= 4'd0;
      end
    end
  end

  // Stage p1: accepted request, driven straight onto the slave bus
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      id_p1    <= REQ0;
      write_p1 <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (accept) begin
      id_p1    <= grant_id;
      write_p1 <= acc_write;
      addr_p1  <= acc_addr;
      wdata_p1 <= acc_wdata;
    end
  end

  assign p_addr  = addr_p1;
  assign p_wdata = wdata_p1;

  // Stage p2: per-requester response data, held until that requester's next response
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata0_p2 <= '0;
      rdata1_p2 <= '0;
    end else if (state == ST_ISSUE) begin
      if (id_p1 == REQ0) rdata0_p2 <= write_p1 ? '0 : p_rdata;
      else               rdata1_p2 <= write_p1 ? '0 : p_rdata;
    end
  end

  assign resp0_rdata = rdata0_p2;
  assign resp1_rdata = rdata1_p2;

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Scoreboard bench for periph_rr_arbiter: directed requests push expected
// grants, strobes and responses; a negedge monitor pops and compares.
module tb_periph_rr_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid, req0_write, req0_lock, req0_ready, resp0_valid;
  logic [1:0]  req0_addr;
  logic [31:0] req0_wdata, resp0_rdata;
  logic        req1_valid, req1_write, req1_lock, req1_ready, resp1_valid;
  logic [1:0]  req1_addr;
  logic [31:0] req1_wdata, resp1_rdata;
  logic [1:0]  p_addr;
  logic        p_rd_en, p_wr_en;
  logic [31:0] p_wdata, p_rdata;

  logic [31:0] mem [4];

  periph_rr_arbiter #(.DATA_W(32), .ADDR_W(2), .MAX_LOCK(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .p_addr(p_addr), .p_rd_en(p_rd_en), .p_wr_en(p_wr_en),
    .p_wdata(p_wdata), .p_rdata(p_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave stub: combinational read, write on the clock edge
  assign p_rdata = p_rd_en ? mem[p_addr] : 32'h0;
  initial for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + i;
  always @(posedge clock) if (p_wr_en) mem[p_addr] <= p_wdata;

  typedef struct packed { logic write; logic [1:0] addr; logic [31:0] wdata; } strobe_t;
  typedef struct packed { logic id; logic [31:0] rdata; } resp_t;

  logic    exp_grant [$];
  strobe_t exp_strobe [$];
  resp_t   exp_resp [$];
  int      ready_cyc [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ready = 0;
  int last_ready = -100;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=event expected=none (cycle %0d)", name, cyc);
  endfunction

  // Monitor
  always @(negedge clock) begin
    logic    gid;
    logic    eg;
    strobe_t es;
    resp_t   er;
    if (req0_ready || req1_ready) begin
      check("single_ready", {req0_ready, req1_ready} == 2'b11, 0);
      gid = req1_ready;
      if (exp_grant.size() == 0) unexpected("grant");
      else begin
        eg = exp_grant.pop_front();
        check("grant_id", gid, eg);
      end
      if (last_ready >= 0) check("ready_spacing", (cyc - last_ready) >= 3, 1);
      last_ready = cyc;
      ready_cyc.push_back(cyc);
      n_ready++;
    end
    if (p_rd_en || p_wr_en) begin
      check("strobe_excl", p_rd_en & p_wr_en, 0);
      check("strobe_latency", cyc, last_ready + 1);
      if (exp_strobe.size() == 0) unexpected("strobe");
      else begin
        es = exp_strobe.pop_front();
        check("strobe_write", p_wr_en, es.write);
        check("strobe_addr", p_addr, es.addr);
        if (es.write) check("strobe_wdata", p_wdata, es.wdata);
      end
    end
    if (resp0_valid || resp1_valid) begin
      check("resp_excl", resp0_valid & resp1_valid, 0);
      check("resp_latency", cyc, last_ready + 2);
      if (exp_resp.size() == 0) unexpected("resp");
      else begin
        er = exp_resp.pop_front();
        check("resp_id", resp1_valid, er.id);
        check("resp_rdata", er.id ? resp1_rdata : resp0_rdata, er.rdata);
      end
    end
    if (!reset_n) last_ready = -100;
  end

  task automatic drive0(input logic v, input logic w, input logic l, input logic [1:0] a, input logic [31:0] d);
    req0_valid = v; req0_write = w; req0_lock = l; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic w, input logic l, input logic [1:0] a, input logic [31:0] d);
    req1_valid = v; req1_write = w; req1_lock = l; req1_addr = a; req1_wdata = d;
  endtask

  task automatic expect_txn(input logic id, input logic w, input logic [1:0] a, input logic [31:0] d,
                            input logic [31:0] rd);
    exp_grant.push_back(id);
    exp_strobe.push_back(strobe_t'{write: w, addr: a, wdata: d});
    exp_resp.push_back(resp_t'{id: id, rdata: rd});
  endtask

  // Returns #1 after the accepting edge, i.e. inside ISSUE
  task automatic wait_ready(input int target, input string name);
    for (int i = 0; i < 60 && n_ready < target; i++) @(posedge clock);
    checks++;
    if (n_ready < target) begin
      errors++;
      $display("FAIL %s_timeout got=%0d expected=%0d", name, n_ready, target);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_grant.size() + exp_strobe.size() + exp_resp.size()) != 0; i++)
      @(posedge clock);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {req0_ready, req1_ready, resp0_valid, resp1_valid, p_rd_en, p_wr_en}, 0);
    check({name, "_bus"}, {p_addr, p_wdata}, 0);
    check({name, "_rdata0"}, resp0_rdata, 0);
    check({name, "_rdata1"}, resp1_rdata, 0);
  endtask

  initial begin
    int base;
    int n;
    reset_n = 1'b0;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Single write then read from requester 0
    base = n_ready;
    expect_txn(0, 1, 2'd0, 32'hA5A5_0001, 32'h0);
    drive0(1, 1, 0, 2'd0, 32'hA5A5_0001);
    wait_ready(base + 1, "wr0");
    drive0(0, 0, 0, 0, 0);
    drain();
    base = n_ready;
    expect_txn(0, 0, 2'd1, 32'h0, 32'h1000_0001);
    drive0(1, 0, 0, 2'd1, 32'h0);
    wait_ready(base + 1, "rd0");
    drive0(0, 0, 0, 0, 0);
    drain();

    // Tie after reset: both held valid, grants alternate starting with 0
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    base = n_ready;
    expect_txn(0, 1, 2'd2, 32'h2222_0000, 32'h0);
    expect_txn(1, 1, 2'd3, 32'h3333_0000, 32'h0);
    expect_txn(0, 1, 2'd2, 32'h2222_0000, 32'h0);
    expect_txn(1, 1, 2'd3, 32'h3333_0000, 32'h0);
    drive0(1, 1, 0, 2'd2, 32'h2222_0000);
    drive1(1, 1, 0, 2'd3, 32'h3333_0000);
    wait_ready(base + 4, "tie");
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    n = ready_cyc.size();
    for (int k = 1; k <= 3; k++)
      if (n > k) check("tie_period", ready_cyc[n-k] - ready_cyc[n-k-1], 3);
    drain();

    // Lock: req1 locked read then unlocked write, req0 waiting throughout
    base = n_ready;
    expect_txn(1, 0, 2'd2, 32'h0, 32'h2222_0000);
    expect_txn(1, 1, 2'd3, 32'h0000_0BBB, 32'h0);
    expect_txn(0, 1, 2'd0, 32'h0000_00AA, 32'h0);
    drive1(1, 0, 1, 2'd2, 32'h0);
    wait_ready(base + 1, "lock_a");
    drive1(1, 1, 0, 2'd3, 32'h0000_0BBB);
    drive0(1, 1, 0, 2'd0, 32'h0000_00AA);
    wait_ready(base + 2, "lock_b");
    drive1(0, 0, 0, 0, 0);
    wait_ready(base + 3, "lock_c");
    drive0(0, 0, 0, 0, 0);
    drain();

    // Lock cap: req1 keeps lock asserted, forced release after 4 grants
    base = n_ready;
    for (int k = 0; k < 4; k++) expect_txn(1, 0, 2'd1, 32'h0, 32'h1000_0001);
    expect_txn(0, 0, 2'd0, 32'h0, 32'h0000_00AA);
    drive1(1, 0, 1, 2'd1, 32'h0);
    drive0(1, 0, 0, 2'd0, 32'h0);
    wait_ready(base + 5, "lock_cap");
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    drain();

    // Reset during ISSUE of a req0 write: strobe happens, response does not
    base = n_ready;
    exp_grant.push_back(0);
    exp_strobe.push_back(strobe_t'{write: 1'b1, addr: 2'd3, wdata: 32'hDEAD_0000});
    drive0(1, 1, 0, 2'd3, 32'hDEAD_0000);
    wait_ready(base + 1, "rst_mid");
    reset_n = 1'b0;
    drive0(0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("rst_mid");
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    base = n_ready;
    expect_txn(0, 0, 2'd3, 32'h0, 32'hDEAD_0000);
    expect_txn(1, 0, 2'd2, 32'h0, 32'h2222_0000);
    drive0(1, 0, 0, 2'd3, 32'h0);
    drive1(1, 0, 0, 2'd2, 32'h0);
    wait_ready(base + 2, "rst_tie");
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    drain();

    // Inputs changing while busy must not reach the slave
    base = n_ready;
    expect_txn(0, 1, 2'd1, 32'h1234_5678, 32'h0);
    expect_txn(1, 0, 2'd0, 32'h0, 32'h0000_00AA);
    drive0(1, 1, 0, 2'd1, 32'h1234_5678);
    wait_ready(base + 1, "busy_a");
    drive0(0, 1, 0, 2'd2, 32'hFFFF_FFFF);
    drive1(1, 0, 0, 2'd0, 32'h0);
    @(posedge clock); #1;
    drive0(0, 1, 1, 2'd3, 32'h0BAD_0BAD);
    wait_ready(base + 2, "busy_b");
    drive1(0, 0, 0, 0, 0);
    drain();

    check("left_grants", exp_grant.size(), 0);
    check("left_strobes", exp_strobe.size(), 0);
    check("left_resps", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
